loop_sequencer: RTL and testbench

- Registered, parametrised successor to the multicycle datapath next-state decoder.
- Holds its own state register and sequences a linear prologue, then a repeating loop body.
- Leaves the loop on a datapath condition or on a programmable iteration limit.
- Adds a start/done handshake, stall, abort, iteration counting and a timeout flag; drives the datapath control decode from State_o.

---
 rtl/loop_sequencer.sv | 142 ++++++++++++++
 tb/tb_loop_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer.sv
// loop_sequencer: registered prologue/loop sequencer for a multicycle datapath.
// Walks states 1..LOOP_LAST once, then repeats LOOP_FIRST..LOOP_LAST until the
// datapath exit condition or the programmed pass limit ends the loop in FIN.
//
// Start/done handshake: Start_i is accepted only on a rising edge where
// State_o == IDLE, and a new sequence begins at the next cycle. Done_o is high
// for exactly the one FIN cycle of a sequence that completed normally. A Start_i
// seen in any other state, FIN included, is dropped rather than queued. Abort_i
// ends a sequence without any Done_o pulse.
module loop_sequencer #(
    parameter int STATE_W    = 4,
    parameter int LOOP_FIRST = 3,
    parameter int LOOP_LAST  = 9,
    parameter int ITER_W     = 8
) (
    input  logic              Clk_i,
    input  logic              Rst_n_i,
    input  logic              Start_i,
    input  logic              Stall_i,
    input  logic              Abort_i,
    input  logic              Exit_i,
    input  logic [ITER_W-1:0] MaxIter_i,
    output logic [STATE_W-1:0] State_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic [ITER_W-1:0] IterCount_o,
    output logic              Timeout_o
);

    localparam logic [STATE_W-1:0] IDLE      = '0;
    localparam logic [STATE_W-1:0] FIRST     = STATE_W'(1);
    localparam logic [STATE_W-1:0] LOOP_TOP  = STATE_W'(LOOP_FIRST);
    localparam logic [STATE_W-1:0] LOOP_END  = STATE_W'(LOOP_LAST);
    localparam logic [STATE_W-1:0] FIN       = STATE_W'(LOOP_LAST + 1);

    // Coarse classification of the numeric state code; the code itself is the
    // register so that State_o can drive the datapath decode directly.
    typedef enum logic [2:0] {
        PH_IDLE,
        PH_BODY,
        PH_LAST,
        PH_FIN,
        PH_ILLEGAL
    } phase_t;

    logic [STATE_W-1:0] stateQ, stateNext;
    logic [ITER_W-1:0]  iterQ, iterNext;
    logic [ITER_W-1:0]  maxIterQ, maxIterNext;
    logic               timeoutQ, timeoutNext;
    logic [ITER_W-1:0]  iterInc;
    phase_t             phase;

    assign iterInc = iterQ + ITER_W'(1);

    // Classify the current state code into the phase that selects the rules.
    always_comb begin
        phase = PH_BODY;
        if (stateQ == IDLE) begin
            phase = PH_IDLE;
        end else if (stateQ == FIN) begin
            phase = PH_FIN;
        end else if (stateQ > FIN) begin
            phase = PH_ILLEGAL;
        end else if (stateQ == LOOP_END) begin
            phase = PH_LAST;
        end
    end

    // Next-state and register updates: abort first, then stall, then flow.
    always_comb begin
        stateNext   = stateQ;
        iterNext    = iterQ;
        maxIterNext = maxIterQ;
        timeoutNext = timeoutQ;
        case (phase)
            PH_IDLE: begin
                if (Start_i) begin
                    stateNext   = FIRST;
                    iterNext    = '0;
                    timeoutNext = 1'b0;
                    maxIterNext = MaxIter_i;
                end
            end
            PH_BODY: begin
                if (Abort_i) begin
                    stateNext = IDLE;
                end else if (!Stall_i) begin
                    stateNext = stateQ + STATE_W'(1);
                end
            end
            PH_LAST: begin
                if (Abort_i) begin
                    stateNext = IDLE;
                end else if (!Stall_i) begin
                    // The pass counts even when it is the one that leaves the loop.
                    iterNext = iterInc;
                    if (Exit_i) begin
                        stateNext   = FIN;
                        timeoutNext = 1'b0;
                    end else if ((maxIterQ != '0) && (iterInc == maxIterQ)) begin
                        stateNext   = FIN;
                        timeoutNext = 1'b1;
                    end else begin
                        stateNext = LOOP_TOP;
                    end
                end
            end
            PH_FIN: begin
                // One cycle only; abort and stall both lead to IDLE anyway.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State, counter, limit and flag registers with asynchronous reset.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            stateQ   <= IDLE;
            iterQ    <= '0;
            maxIterQ <= '0;
            timeoutQ <= 1'b0;
        end else begin
            stateQ   <= stateNext;
            iterQ    <= iterNext;
            maxIterQ <= maxIterNext;
            timeoutQ <= timeoutNext;
        end
    end

    // Status outputs are pure decodes of the registered state.
    always_comb begin
        State_o     = stateQ;
        Busy_o      = (stateQ != IDLE);
        Done_o      = (stateQ == FIN);
        IterCount_o = iterQ;
        Timeout_o   = timeoutQ;
    end

endmodule

// File: tb/tb_loop_sequencer.sv
// Bench for loop_sequencer: default instance plus a one-state-loop instance,
// both compared every cycle against an integer reference model.
module tb_loop_sequencer;

    logic clk;
    logic rstN;

    logic       startA, stallA, abortA, exitA;
    logic [7:0] maxA;
    logic [3:0] stateA;
    logic       busyA, doneA, toOutA;
    logic [7:0] iterA;

    logic       startB, stallB, abortB, exitB;
    logic [1:0] maxB;
    logic [1:0] stateB;
    logic       busyB, doneB, toOutB;
    logic [1:0] iterB;

    int stA, itA, toA, mxA;
    int stB, itB, toB, mxB;

    logic [31:0] exp_q[$];
    int nChecks;
    int nFail;

    loop_sequencer dutA (
        .Clk_i(clk), .Rst_n_i(rstN), .Start_i(startA), .Stall_i(stallA),
        .Abort_i(abortA), .Exit_i(exitA), .MaxIter_i(maxA), .State_o(stateA),
        .Busy_o(busyA), .Done_o(doneA), .IterCount_o(iterA), .Timeout_o(toOutA)
    );

    loop_sequencer #(.STATE_W(2), .LOOP_FIRST(2), .LOOP_LAST(2), .ITER_W(2)) dutB (
        .Clk_i(clk), .Rst_n_i(rstN), .Start_i(startB), .Stall_i(stallB),
        .Abort_i(abortB), .Exit_i(exitB), .MaxIter_i(maxB), .State_o(stateB),
        .Busy_o(busyB), .Done_o(doneB), .IterCount_o(iterB), .Timeout_o(toOutB)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference model: one rising edge of a sequencer with loop [lf..ll], FIN = ll+1.
    task automatic modelStep(input int lf, input int ll, input int iw,
                             input bit start, input bit stall, input bit abort,
                             input bit exitc, input int maxIn,
                             inout int st, inout int it, inout int to, inout int mx);
        int fin;
        fin = ll + 1;
        if (st == 0) begin
            if (start) begin
                st = 1; it = 0; to = 0; mx = maxIn;
            end
        end else if (st > fin || abort || st == fin) begin
            st = 0;
        end else if (stall) begin
            st = st;
        end else if (st < ll) begin
            st = st + 1;
        end else begin
            it = (it + 1) % (1 << iw);
            if (exitc) begin
                st = fin; to = 0;
            end else if (mx != 0 && it == mx) begin
                st = fin; to = 1;
            end else begin
                st = lf;
            end
        end
    endtask

    function automatic logic [31:0] packA();
        return 32'({4'(stA), 1'(stA != 0), 1'(stA == 10), 8'(itA), 1'(toA)});
    endfunction

    function automatic logic [31:0] packB();
        return 32'({2'(stB), 1'(stB != 0), 1'(stB == 3), 2'(itB), 1'(toB)});
    endfunction

    function automatic logic [31:0] obsA();
        return 32'({stateA, busyA, doneA, iterA, toOutA});
    endfunction

    function automatic logic [31:0] obsB();
        return 32'({stateB, busyB, doneB, iterB, toOutB});
    endfunction

    // driver: one clock edge, advance the model, score both instances
    task automatic tick();
        logic [31:0] ea;
        logic [31:0] eb;
        @(posedge clk);
        #1;
        modelStep(3, 9, 8, startA, stallA, abortA, exitA, int'(maxA), stA, itA, toA, mxA);
        modelStep(2, 2, 2, startB, stallB, abortB, exitB, int'(maxB), stB, itB, toB, mxB);
        exp_q.push_back(packA());
        exp_q.push_back(packB());
        ea = exp_q.pop_front();
        eb = exp_q.pop_front();
        checkVal("seqA", obsA(), ea);
        checkVal("seqB", obsB(), eb);
    endtask

    task automatic modelReset();
        stA = 0; itA = 0; toA = 0; mxA = 0;
        stB = 0; itB = 0; toB = 0; mxB = 0;
    endtask

    task automatic waitIdleA(input string tag);
        int g;
        g = 0;
        while (busyA && g < 100) begin
            tick();
            g++;
        end
        checkVal(tag, 32'(busyA), 32'd0);
    endtask

    initial begin
        int n;
        int g;
        int cnt;
        bit flag;
        bit sawDone;
        nChecks = 0;
        nFail = 0;
        startA = 0; stallA = 0; abortA = 0; exitA = 0; maxA = '0;
        startB = 0; stallB = 0; abortB = 0; exitB = 0; maxB = '0;
        modelReset();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_stateA", 32'(stateA), 32'd0);
        checkVal("rst_flagsA", 32'({busyA, doneA, toOutA}), 32'd0);
        checkVal("rst_iterA", 32'(iterA), 32'd0);
        checkVal("rst_B", obsB(), 32'd0);
        @(negedge clk);
        rstN = 1'b1;

        // T1: exit on the first pass, no limit
        maxA = 8'd0; exitA = 1; startA = 1;
        tick();
        startA = 0;
        for (int k = 1; k <= 9; k++) begin
            checkVal("t1_step", 32'(stateA), 32'(k));
            tick();
        end
        checkVal("t1_fin", 32'({stateA, doneA}), 32'({4'd10, 1'b1}));
        checkVal("t1_iter", 32'({iterA, toOutA}), 32'({8'd1, 1'b0}));
        tick();
        checkVal("t1_idle", 32'({stateA, doneA, busyA}), 32'd0);

        // T2: pass limit of 3
        maxA = 8'd3; exitA = 0; startA = 1;
        tick();
        startA = 0;
        n = 1;
        while (!doneA && n < 100) begin
            tick();
            n++;
        end
        checkVal("t2_fin_cycle", 32'(n), 32'd24);
        checkVal("t2_iter", 32'(iterA), 32'd3);
        checkVal("t2_timeout", 32'(toOutA), 32'd1);
        tick();
        maxA = 8'd0; exitA = 1; startA = 1;
        tick();
        startA = 0;
        checkVal("t2_restart_clr", 32'({iterA, toOutA}), 32'd0);
        waitIdleA("t2_idle");

        // T3: exit and limit in the same cycle, exit wins
        maxA = 8'd2; exitA = 0; startA = 1;
        tick();
        startA = 0;
        cnt = 0; g = 0;
        while (!doneA && g < 100) begin
            if (stateA == 4'd9) cnt++;
            exitA = (stateA == 4'd9 && cnt == 2);
            tick();
            g++;
        end
        exitA = 0;
        checkVal("t3_done", 32'(doneA), 32'd1);
        checkVal("t3_timeout", 32'(toOutA), 32'd0);
        checkVal("t3_iter", 32'(iterA), 32'd2);
        waitIdleA("t3_idle");

        // T4: three-cycle stall at state 5, then a start while busy
        maxA = 8'd0; exitA = 1; startA = 1;
        tick();
        startA = 0;
        n = 1;
        while (stateA != 4'd5 && n < 100) begin
            tick();
            n++;
        end
        stallA = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n++;
            checkVal("t4_stall_hold", 32'(stateA), 32'd5);
        end
        stallA = 0;
        startA = 1;
        tick();
        n++;
        startA = 0;
        while (!doneA && n < 100) begin
            tick();
            n++;
        end
        checkVal("t4_fin_cycle", 32'(n), 32'd13);
        waitIdleA("t4_idle");

        // T5: abort at state 7 on the second pass
        maxA = 8'd0; exitA = 0; startA = 1;
        tick();
        startA = 0;
        cnt = 0; g = 0; flag = 0; sawDone = 0;
        while (!flag && g < 100) begin
            if (stateA == 4'd7) cnt++;
            if (cnt == 2) begin
                abortA = 1;
                tick();
                abortA = 0;
                flag = 1;
            end else begin
                tick();
            end
            sawDone |= doneA;
            g++;
        end
        checkVal("t5_abort_idle", 32'({stateA, busyA}), 32'd0);
        checkVal("t5_no_done", 32'(sawDone), 32'd0);
        tick();
        tick();
        checkVal("t5_iter_held", 32'(iterA), 32'd1);

        // T5b: asynchronous reset mid-sequence
        startA = 1;
        tick();
        startA = 0;
        g = 0;
        while (stateA != 4'd4 && g < 100) begin
            tick();
            g++;
        end
        #2;
        rstN = 1'b0;
        #1;
        checkVal("t5_async_rst", 32'({stateA, busyA, iterA}), 32'd0);
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // T6: one-state loop, 2-bit counter wraps, exit after six passes
        maxB = 2'd0; exitB = 0; startB = 1;
        tick();
        startB = 0;
        cnt = 0; g = 0;
        while (stateB != 2'd3 && g < 100) begin
            exitB = (cnt == 5);
            if (stateB == 2'd2) cnt++;
            tick();
            if (cnt == 4 && stateB == 2'd2 && !exitB) checkVal("t6_wrap", 32'(iterB), 32'd0);
            g++;
        end
        exitB = 0;
        checkVal("t6_done", 32'(doneB), 32'd1);
        checkVal("t6_iter", 32'(iterB), 32'd2);
        checkVal("t6_timeout", 32'(toOutB), 32'd0);
        tick();

        // Randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            startA = ($urandom_range(0, 3) == 0);
            stallA = ($urandom_range(0, 7) == 0);
            abortA = ($urandom_range(0, 40) == 0);
            exitA  = ($urandom_range(0, 5) == 0);
            maxA   = 8'($urandom_range(0, 4));
            startB = ($urandom_range(0, 2) == 0);
            stallB = ($urandom_range(0, 5) == 0);
            abortB = ($urandom_range(0, 30) == 0);
            exitB  = ($urandom_range(0, 6) == 0);
            maxB   = 2'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", nChecks, nFail);
        $finish;
    end

endmodule
